// File: rtl/bdd_traverse_ctrl.sv
// Decision-tree traversal sequencer: fetches node words, streams coefficients into an
// external MAC, follows left/right children until a leaf or the depth limit is reached.
module bdd_traverse_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int N_ATTR     = 4,
    parameter int COEF_AW    = 2,
    parameter int THR_WIDTH  = 16,
    parameter int MAX_DEPTH  = 16,
    parameter int ROOT_ADDR  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    output logic                         class_valid,
    input  logic                         class_ready,
    output logic [7:0]                   class_out,
    output logic                         err,
    output logic                         busy,
    input  logic                         host_we,
    input  logic                         host_sel,
    input  logic [ADDR_WIDTH+COEF_AW-1:0] host_addr,
    output logic                         host_wr_ack,
    output logic [ADDR_WIDTH-1:0]        node_addr,
    output logic                         node_re,
    output logic                         node_we,
    input  logic [18+THR_WIDTH-1:0]      node_rdata,
    output logic [ADDR_WIDTH+COEF_AW-1:0] coef_addr,
    output logic                         coef_re,
    output logic                         coef_we,
    output logic [COEF_AW-1:0]           attr_idx,
    output logic                         mac_clr,
    output logic                         mac_en,
    input  logic [THR_WIDTH-1:0]         mac_acc
);
    localparam int NODE_W  = 18 + THR_WIDTH;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    // Handshakes (start, class) complete on a rising edge where valid and ready are both
    // high; a valid never depends combinationally on its ready.
    typedef enum logic [2:0] {
        S_IDLE, S_NODE_RD, S_NODE_LAT, S_MAC, S_DRAIN, S_CMP, S_RESULT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] node_q, node_d;
    logic [NODE_W-1:0]     word_q, word_d;
    logic [COEF_AW-1:0]    k_q, k_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [7:0]            cls_q, cls_d;
    logic                  err_q, err_d;
    logic                  mac_en_q, mac_clr_q;
    logic [COEF_AW-1:0]    attr_q;

    logic [8:0]            left_w, right_w, sel_w;
    logic [THR_WIDTH-1:0]  thr_w;

    assign left_w  = word_q[NODE_W-1 -: 9];
    assign right_w = word_q[THR_WIDTH+8 -: 9];
    assign thr_w   = word_q[THR_WIDTH-1:0];
    // Unsigned compare, a tie goes to the left child.
    assign sel_w   = (mac_acc <= thr_w) ? left_w : right_w;

    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        word_d      = word_q;
        k_d         = k_q;
        depth_d     = depth_q;
        cls_d       = cls_q;
        err_d       = err_q;
        start_ready = 1'b0;
        class_valid = 1'b0;
        host_wr_ack = 1'b0;
        node_addr   = '0;
        node_re     = 1'b0;
        node_we     = 1'b0;
        coef_addr   = '0;
        coef_re     = 1'b0;
        coef_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                start_ready = !host_we;
                if (host_we) begin
                    host_wr_ack = 1'b1;
                    node_we     = host_sel;
                    coef_we     = !host_sel;
                    node_addr   = host_addr[ADDR_WIDTH-1:0];
                    coef_addr   = host_addr;
                end else if (start_valid) begin
                    state_d = S_NODE_RD;
                    node_d  = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d = '0;
                end
            end
            S_NODE_RD: begin
                node_re   = 1'b1;
                node_addr = node_q;
                state_d   = S_NODE_LAT;
            end
            S_NODE_LAT: begin
                word_d  = node_rdata;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                coef_re   = 1'b1;
                coef_addr = {node_q, k_q};
                k_d       = k_q + COEF_AW'(1);
                if (k_q == COEF_AW'(N_ATTR - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_CMP;
            S_CMP: begin
                depth_d = depth_q + DEPTH_W'(1);
                if (sel_w[8]) begin
                    state_d = S_RESULT;
                    cls_d   = sel_w[7:0];
                    err_d   = 1'b0;
                end else if (depth_q + DEPTH_W'(1) == DEPTH_W'(MAX_DEPTH)) begin
                    state_d = S_RESULT;
                    cls_d   = 8'h00;
                    err_d   = 1'b1;
                end else begin
                    node_d  = ADDR_WIDTH'(sel_w[7:0]);
                    state_d = S_NODE_RD;
                end
            end
            S_RESULT: begin
                class_valid = 1'b1;
                if (class_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            node_q    <= ADDR_WIDTH'(ROOT_ADDR);
            word_q    <= '0;
            k_q       <= '0;
            depth_q   <= '0;
            cls_q     <= '0;
            err_q     <= 1'b0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            attr_q    <= '0;
        end else begin
            state_q   <= state_d;
            node_q    <= node_d;
            word_q    <= word_d;
            k_q       <= k_d;
            depth_q   <= depth_d;
            cls_q     <= cls_d;
            err_q     <= err_d;
            // MAC strobes trail the coefficient read by the RAM latency.
            mac_en_q  <= (state_q == S_MAC);
            mac_clr_q <= (state_q == S_MAC) && (k_q == '0);
            attr_q    <= (state_q == S_MAC) ? k_q : '0;
        end
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_RESULT);
    assign class_out = cls_q;
    assign err       = err_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign attr_idx  = attr_q;

endmodule

// File: tb/tb_bdd_traverse_ctrl.sv
// Bench for bdd_traverse_ctrl: RAM and MAC models, a loop-based traversal reference,
// and a monitor that checks results, coefficient addresses and handshake rules.
module tb_bdd_traverse_ctrl;
    localparam int CLK       = 10;
    localparam int N_ATTR    = 4;
    localparam int MAX_DEPTH = 16;
    localparam int ROOT      = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0, start_ready;
    logic        class_valid, class_ready = 1'b0;
    logic [7:0]  class_out;
    logic        err, busy;
    logic        host_we = 1'b0, host_sel = 1'b0, host_wr_ack;
    logic [9:0]  host_addr = '0;
    logic [7:0]  node_addr;
    logic        node_re, node_we;
    logic [33:0] node_rdata = '0;
    logic [9:0]  coef_addr;
    logic        coef_re, coef_we;
    logic [1:0]  attr_idx;
    logic        mac_clr, mac_en;
    logic [15:0] mac_acc = '0;

    logic [33:0] node_wdata = '0;
    logic [7:0]  coef_wdata = '0;
    logic [7:0]  coef_rdata = '0;
    logic [33:0] node_mem [0:255];
    logic [7:0]  coef_mem [0:1023];
    logic [33:0] ref_node [0:255];
    logic [7:0]  ref_coef [0:1023];
    logic [7:0]  sample [0:N_ATTR-1];

    logic [24:0] exp_q[$];
    logic [9:0]  exp_coef_q[$];
    int n_checks = 0, n_fail = 0, cyc = 0, done_cnt = 0;
    int hs_edge = 0, rise_cyc = 0;
    logic cv_prev = 1'b0, hs_prev = 1'b0, held_err = 1'b0;
    logic [7:0] held_cls = '0;

    bdd_traverse_ctrl #(
        .ADDR_WIDTH(8), .N_ATTR(N_ATTR), .COEF_AW(2), .THR_WIDTH(16),
        .MAX_DEPTH(MAX_DEPTH), .ROOT_ADDR(ROOT)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .class_valid(class_valid), .class_ready(class_ready),
        .class_out(class_out), .err(err), .busy(busy),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
        .host_wr_ack(host_wr_ack),
        .node_addr(node_addr), .node_re(node_re), .node_we(node_we), .node_rdata(node_rdata),
        .coef_addr(coef_addr), .coef_re(coef_re), .coef_we(coef_we),
        .attr_idx(attr_idx), .mac_clr(mac_clr), .mac_en(mac_en), .mac_acc(mac_acc)
    );

    // Clock / environment: 1-cycle RAMs and a multiply-accumulate unit.
    always #(CLK/2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (node_re) node_rdata <= node_mem[node_addr];
        if (node_we) node_mem[node_addr] <= node_wdata;
        if (coef_re) coef_rdata <= coef_mem[coef_addr];
        if (coef_we) coef_mem[coef_addr] <= coef_wdata;
        if (mac_en)
            mac_acc <= (mac_clr ? 16'd0 : mac_acc) + {8'd0, coef_rdata} * {8'd0, sample[attr_idx]};
    end

    initial begin
        #(CLK * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the tree from the root using the written tables.
    task automatic ref_traverse(output logic [7:0] cls, output logic e, output int visits);
        logic [7:0]  n;
        logic [15:0] acc;
        logic [33:0] w;
        logic [8:0]  sel;
        n = 8'(ROOT); cls = '0; e = 1'b0; visits = 0;
        for (int v = 1; v <= MAX_DEPTH; v++) begin
            acc = '0;
            for (int k = 0; k < N_ATTR; k++) begin
                exp_coef_q.push_back({n, 2'(k)});
                acc = acc + 16'(ref_coef[{n, 2'(k)}]) * 16'(sample[k]);
            end
            w = ref_node[n];
            sel = (acc <= w[15:0]) ? w[33:25] : w[24:16];
            visits = v;
            if (sel[8]) begin
                cls = sel[7:0];
                return;
            end
            if (v == MAX_DEPTH) begin
                e = 1'b1;
                return;
            end
            n = sel[7:0];
        end
    endtask

    // Monitor: samples on the falling edge.
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst) begin
            cv_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) check("valid_drop", class_valid, 0);
            if (coef_re) begin
                check("busy_mac", busy, 1);
                if (exp_coef_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL coef_addr: unexpected read of %0h at cycle %0d", coef_addr, cyc);
                end else check("coef_addr", coef_addr, exp_coef_q.pop_front());
            end
            if (node_we || coef_we || host_wr_ack) begin
                check("we_gate", {node_we, coef_we}, host_wr_ack ? {host_sel, !host_sel} : 2'b00);
                check("ack_state", {busy, class_valid}, 0);
            end
            if (class_valid) begin
                check("result_start_ready", start_ready, 0);
                check("result_ack", host_wr_ack, 0);
                check("result_busy", busy, 0);
                if (cv_prev) begin
                    check("hold_class", class_out, held_cls);
                    check("hold_err", err, held_err);
                end else rise_cyc = cyc;
                held_cls = class_out;
                held_err = err;
            end
            if (start_valid && start_ready) hs_edge = cyc + 1;
            hs_prev = class_valid && class_ready;
            cv_prev = class_valid && !class_ready;
            if (hs_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL class_result: unexpected result %0h at cycle %0d", class_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("class_out", class_out, e[23:16]);
                    check("err", err, e[24]);
                    check("latency", rise_cyc - hs_edge, e[15:0]);
                end
                done_cnt++;
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic host_write(input logic sel, input logic [9:0] addr, input logic [33:0] data);
        int n = 0;
        bit got = 0;
        if (sel) ref_node[addr[7:0]] = data;
        else     ref_coef[addr] = data[7:0];
        host_we = 1'b1; host_sel = sel; host_addr = addr;
        node_wdata = data; coef_wdata = data[7:0];
        while (!got && n < 50) begin
            @(negedge clk); got = host_wr_ack;
            @(posedge clk); #1; n++;
        end
        host_we = 1'b0;
        check("host_ack", got, 1);
    endtask

    task automatic load_coefs();
        for (int n = 0; n < 16; n++)
            for (int k = 0; k < N_ATTR; k++)
                host_write(1'b0, {8'(n), 2'(k)}, 34'($urandom_range(0, 255)));
    endtask

    function automatic logic [8:0] rand_child();
        if ($urandom_range(0, 2) == 0) return {1'b1, 8'($urandom_range(0, 255))};
        return {1'b0, 8'($urandom_range(0, 15))};
    endfunction

    task automatic random_tree();
        for (int n = 0; n < 16; n++)
            host_write(1'b1, 10'(n), {rand_child(), rand_child(), 16'($urandom)});
        load_coefs();
    endtask

    // mode 0: random class_ready; 1: directed RESULT backpressure; 2: host_we during MAC.
    task automatic classify(input int mode);
        logic [7:0] cls;
        logic e;
        int visits, n, n0;
        bit got;
        ref_traverse(cls, e, visits);
        exp_q.push_back({e, cls, 16'(visits * 8)});
        start_valid = 1'b1; n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); got = start_ready;
            @(posedge clk); #1; n++;
        end
        start_valid = 1'b0;
        check("start_hs", got, 1);
        if (mode == 2) begin
            repeat (3) @(posedge clk);
            #1;
            host_we = 1'b1; host_sel = $urandom_range(0, 1); host_addr = 10'h3FF;
            repeat (3) begin
                @(negedge clk);
                check("mac_host_ack", host_wr_ack, 0);
                check("mac_we", {node_we, coef_we}, 0);
                @(posedge clk); #1;
            end
            host_we = 1'b0;
        end
        if (mode == 1) begin
            n = 0; got = 0;
            while (!got && n < 300) begin
                @(negedge clk); got = class_valid; n++;
            end
            check("valid_seen", got, 1);
            @(posedge clk); #1;
            start_valid = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; class_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            start_valid = 1'b0; host_we = 1'b0; class_ready = 1'b1;
        end
        n0 = done_cnt; n = 0;
        while (done_cnt == n0 && n < 400) begin
            if (mode != 1) class_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        class_ready = 1'b0;
        check("result_done", done_cnt != n0, 1);
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {class_valid, err, class_out, busy, host_wr_ack, node_addr, node_re, node_we,
                     coef_addr, coef_re, coef_we, attr_idx, mac_clr, mac_en}, 0);
        check({name, "_start_ready"}, start_ready, 1);
    endtask

    initial begin
        int n;
        bit got;
        for (int k = 0; k < N_ATTR; k++) sample[k] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_state");
        @(posedge clk); #1;
        load_coefs();

        // Single node, threshold tie goes left, one above goes right.
        host_write(1'b1, 10'd0, {9'h105, 9'h10A, 16'd100});
        host_write(1'b0, 10'd0, 34'd100);
        host_write(1'b0, 10'd1, 34'd1);
        host_write(1'b0, 10'd2, 34'd0);
        host_write(1'b0, 10'd3, 34'd0);
        sample[0] = 8'd1; sample[1] = 8'd0; sample[2] = 8'd0; sample[3] = 8'd0;
        classify(0);
        sample[1] = 8'd1;
        classify(0);

        // Three-level path 0 -> 3 -> 7 -> leaf 0x21.
        host_write(1'b1, 10'd0, {9'h003, 9'h003, 16'h1234});
        host_write(1'b1, 10'd3, {9'h007, 9'h007, 16'h0042});
        host_write(1'b1, 10'd7, {9'h121, 9'h121, 16'hFFFF});
        classify(0);

        // RESULT backpressure with start and host requests pending.
        classify(1);

        // Self-loop at the root runs into the depth limit.
        host_write(1'b1, 10'd0, {9'h000, 9'h000, 16'h0000});
        classify(0);

        // Host wins over start in IDLE.
        ref_node[5] = {9'h155, 9'h155, 16'h0005};
        host_we = 1'b1; host_sel = 1'b1; host_addr = 10'd5; node_wdata = ref_node[5];
        start_valid = 1'b1;
        @(negedge clk);
        check("arb_ack", host_wr_ack, 1);
        check("arb_start_ready", start_ready, 0);
        check("arb_we", {node_we, coef_we}, 2'b10);
        check("arb_node_addr", node_addr, 5);
        @(posedge clk); #1;
        ref_coef[10'h2C3] = 8'h5A;
        host_sel = 1'b0; host_addr = 10'h2C3; coef_wdata = 8'h5A;
        @(negedge clk);
        check("arb_coef_we", {node_we, coef_we}, 2'b01);
        check("arb_coef_addr", coef_addr, 10'h2C3);
        @(posedge clk); #1;
        host_we = 1'b0; start_valid = 1'b0;
        @(negedge clk);
        check("arb_no_start", busy, 0);
        @(posedge clk); #1;
        host_write(1'b1, 10'd0, {9'h005, 9'h005, 16'h0000});
        classify(2);

        // Reset during the MAC phase of node 2, then a clean traversal from the root.
        host_write(1'b1, 10'd0, {9'h001, 9'h001, 16'h0000});
        host_write(1'b1, 10'd1, {9'h002, 9'h002, 16'h0000});
        host_write(1'b1, 10'd2, {9'h003, 9'h003, 16'h0000});
        host_write(1'b1, 10'd3, {9'h142, 9'h142, 16'h0000});
        begin
            logic [7:0] c;
            logic e;
            int v;
            ref_traverse(c, e, v);
        end
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n = 0; got = 0;
        while (!got && n < 100) begin
            @(negedge clk); got = coef_re && (coef_addr[9:2] == 8'd2); n++;
        end
        check("reach_node2", got, 1);
        @(posedge clk); #1 rst = 1'b1;
        exp_coef_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_reset");
        @(posedge clk); #1;
        classify(0);

        // Randomized trees and samples.
        repeat (2) begin
            random_tree();
            repeat (20) begin
                for (int k = 0; k < N_ATTR; k++) sample[k] = 8'($urandom_range(0, 255));
                classify(0);
            end
        end

        repeat (3) @(posedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_coef_q_empty", exp_coef_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
